instr_fetch: RTL and testbench

Multicycle fetch sequencer that drives the instruction register's load side: holds the PC, issues a word-read request to instruction memory on a start pulse from the main control FSM, and waits for the memory handshake. It then presents the returned word on instr_out with a one-cycle ir_write strobe and advances the PC by 4. It sits between the control FSM, the instruction memory port, and instr_reg (instr_out feeds instr_in, ir_write feeds IRWrite).

---
 rtl/cpu_defs.sv | 14 +
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch_pc_reg.sv | 25 ++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, PC step and the fetch state encoding.
package cpu_defs;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: fetch unit is master, memory is slave.
interface instr_fetch_if;
  import cpu_defs::*;

  logic               mem_req;
  logic [INSTR_W-1:0] mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async active-low reset, parallel load, and +PC_STEP increment.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic [INSTR_W-1:0] load_val,
  output logic [INSTR_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + INSTR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch sequencer (IDLE -> REQ -> WRITE) with request timeout.
// Define FETCH_COUNT_EN to add the fetch_count output counting completed fetches.
module instr_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pc_load,
  input  logic [31:0]   pc_in,
  instr_fetch_if.master mem,
  output logic [31:0]   instr_out,
  output logic          ir_write,
  output logic [31:0]   pc_out,
  output logic          busy,
  output logic          done,
  output logic          fault
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);

  fetch_state_t         state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_next;
  logic [31:0]          sel_pc;
  logic                 pc_ld;
  logic                 pc_inc;

  // A same-cycle pc_load takes priority, so the fetch address is the new target.
  assign sel_pc    = pc_load ? pc_in : pc_out;
  assign pc_ld     = (state == IDLE) && pc_load;
  assign pc_inc    = (state == WRITE);
  assign wait_next = wait_cnt + 1'b1;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_ld),
    .inc      (pc_inc),
    .load_val (pc_in),
    .pc       (pc_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      instr_out    <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      ir_write     <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ir_write <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (sel_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
            end else begin
              state        <= REQ;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= sel_pc;
              busy         <= 1'b1;
              wait_cnt     <= '0;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            instr_out   <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            ir_write    <= 1'b1;
            done        <= 1'b1;
            state       <= WRITE;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
              mem.mem_req <= 1'b0;
              fault       <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (state == WRITE) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table plus randomized fetches vs. a transaction model.
module tb_instr_fetch;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pc_load;
  logic [31:0] pc_in;
  logic [31:0] instr_out;
  logic        ir_write;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;
  logic        fault;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .mem       (bus),
    .instr_out (instr_out),
    .ir_write  (ir_write),
    .pc_out    (pc_out),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;

  typedef struct {
    bit          load;
    logic [31:0] pin;
    int          dly;
    logic [31:0] data;
    bit          noise;
    int          kind;   // 0 = fetched, 1 = misaligned fault, 2 = timeout fault
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic int outcome(input logic [31:0] sel, input int dly);
    if (sel[1:0] != 2'b00) return 1;
    if (dly >= TMO) return 2;
    return 0;
  endfunction

  // One fetch attempt; the bench plays the memory, answering after dly REQ cycles.
  task automatic run_fetch(input string tag, input bit load, input logic [31:0] pin,
                           input int dly, input logic [31:0] data, input bit noise,
                           input int kind, input logic [31:0] exp_pc,
                           input logic [31:0] exp_instr, input logic [31:0] exp_addr);
    int k, reqc, ir_k, flt_k, exp_k;
    bit addr_ok;
    @(negedge clk);
    start = 1'b1; pc_load = load; pc_in = pin; bus.mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; pc_load = 1'b0; pc_in = $urandom;
    k = 1; reqc = 0; ir_k = 0; flt_k = 0; addr_ok = 1'b1;
    while (1) begin
      if (bus.mem_req && bus.mem_addr !== exp_addr) addr_ok = 1'b0;
      if (ir_write) begin
        ir_k = k;
        chk({tag, " instr_at_ir_write"}, instr_out, exp_instr);
        chk({tag, " done_with_ir_write"}, {31'd0, done}, 32'd1);
      end
      if (fault) flt_k = k;
      if (ir_k != 0 || flt_k != 0 || k > 40) break;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (reqc == dly) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = data;
        end
        reqc++;
      end
      if (noise && busy) begin
        start = 1'b1; pc_load = 1'b1; pc_in = $urandom;
      end else begin
        start = 1'b0; pc_load = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; pc_load = 1'b0; bus.mem_ready = 1'b0;
    exp_k = (kind == 0) ? dly + 2 : (kind == 1) ? 1 : TMO + 1;
    chk({tag, " ir_write_cycle"}, ir_k, (kind == 0) ? exp_k : 0);
    chk({tag, " fault_cycle"}, flt_k, (kind == 0) ? 0 : exp_k);
    chk({tag, " req_cycles"}, reqc, (kind == 0) ? dly + 1 : (kind == 1) ? 0 : TMO);
    chk({tag, " mem_addr"}, {31'd0, addr_ok}, 32'd1);
    @(negedge clk);
    chk({tag, " pc_out"}, pc_out, exp_pc);
    chk({tag, " instr_hold"}, instr_out, exp_instr);
    chk({tag, " idle_flags"}, {28'd0, busy, fault, ir_write, done}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk({tag, " fetch_count"}, fetch_count, m_count + ((kind == 0) ? 32'd1 : 32'd0));
`endif
    m_pc = exp_pc;
    m_instr = exp_instr;
    if (kind == 0) m_count = m_count + 32'd1;
  endtask

  task automatic model_fetch(input string tag, input bit load, input logic [31:0] pin,
                             input int dly, input logic [31:0] data, input bit noise);
    logic [31:0] sel;
    int kind;
    sel  = load ? pin : m_pc;
    kind = outcome(sel, dly);
    run_fetch(tag, load, pin, dly, data, noise, kind,
              (kind == 0) ? sel + 32'd4 : sel,
              (kind == 0) ? data : m_instr, sel);
  endtask

  initial begin
    tbl[0] = '{0, 32'h0000_0000,  0, 32'h212A_000A, 0, 0, 32'h0000_0004, 32'h212A_000A, 32'h0000_0000};
    tbl[1] = '{1, 32'h0000_0040,  3, 32'h8C08_0004, 1, 0, 32'h0000_0044, 32'h8C08_0004, 32'h0000_0040};
    tbl[2] = '{1, 32'h0000_0042,  0, 32'h0000_0000, 0, 1, 32'h0000_0042, 32'h8C08_0004, 32'h0000_0042};
    tbl[3] = '{1, 32'h0000_0100, 99, 32'h0000_0000, 1, 2, 32'h0000_0100, 32'h8C08_0004, 32'h0000_0100};
    tbl[4] = '{1, 32'hFFFF_FFFC,  1, 32'hAFBF_0010, 0, 0, 32'h0000_0000, 32'hAFBF_0010, 32'hFFFF_FFFC};
    tbl[5] = '{0, 32'h0000_0000, 15, 32'h1234_5678, 0, 0, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000};
    tbl[6] = '{0, 32'h0000_0000, 16, 32'h0000_0000, 0, 2, 32'h0000_0004, 32'h1234_5678, 32'h0000_0004};

    reset = 1'b0; start = 1'b0; pc_load = 1'b0; pc_in = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset instr_out", instr_out, 32'h0);
    chk("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset flags", {28'd0, busy, fault, ir_write, done}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk("reset fetch_count", fetch_count, 32'h0);
`endif

    for (int i = 0; i < 7; i++) begin
      run_fetch($sformatf("vec%0d", i), tbl[i].load, tbl[i].pin, tbl[i].dly, tbl[i].data,
                tbl[i].noise, tbl[i].kind, tbl[i].pc, tbl[i].instr, tbl[i].addr);
    end

    // Separate load then start of a misaligned target
    pc_load = 1'b1; pc_in = 32'h0000_0042;
    @(negedge clk);
    pc_load = 1'b0;
    chk("preload pc_out", pc_out, 32'h0000_0042);
    m_pc = 32'h0000_0042;
    run_fetch("misalign_seq", 1'b0, 32'h0, 0, 32'h0, 1'b0, 1, 32'h0000_0042, m_instr, 32'h0000_0042);

    // mem_ready while idle must not disturb instr_out
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("idle_ready instr_out", instr_out, m_instr);
    chk("idle_ready ir_write", {31'd0, ir_write}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] pin;
      bit load;
      load = ($urandom_range(0, 2) == 0);
      pin = $urandom;
      if ($urandom_range(0, 4) != 0) pin[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) pin = 32'hFFFF_FFFC;
      model_fetch($sformatf("rnd%0d", i), load, pin, $urandom_range(0, 19), $urandom,
                  bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    start = 1'b1; pc_load = 1'b1; pc_in = 32'h0000_0200;
    @(negedge clk);
    start = 1'b0; pc_load = 1'b0;
    chk("midreq mem_req_before", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreq mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midreq pc_out", pc_out, 32'h0);
    chk("midreq busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    model_fetch("post_reset", 1'b0, 32'h0, 2, 32'h0149_0020, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
